// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one sel/wr/addr/wdata/rdata/ready register slave among
// NUM_REQ requesters; one transaction in flight, completed by a one-cycle one-hot ack.
module reg_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            err,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      gnt_id,
    output logic                            m_sel,
    output logic                            m_wr,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic                            m_ready
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA, S_DONE} state_t;

    state_t                 r_state;
    logic [GW-1:0]          r_ptr;
    logic [GW-1:0]          r_gnt;
    logic [CW-1:0]          r_cnt;
    logic                   r_wr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_busy;

    logic                   w_found;
    logic [GW-1:0]          w_pick;
    logic [GW:0]            w_sum;
    logic [GW-1:0]          w_idx;
    logic [NUM_REQ-1:0]     w_gnt_oh;
    logic [GW-1:0]          w_ptr_nxt;

    // First set request at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (GW+1)'(k);
            w_idx = (w_sum >= (GW+1)'(NUM_REQ)) ? GW'(w_sum - (GW+1)'(NUM_REQ)) : w_sum[GW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_gnt_oh  = NUM_REQ'(1) << r_gnt;
    assign w_ptr_nxt = (r_gnt == GW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                        r_gnt   <= w_pick;
                        r_wr    <= req_wr[w_pick];
                        r_addr  <= req_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= req_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
                        r_cnt   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        if (r_wr) begin
                            r_state <= S_DONE;
                            r_ack   <= w_gnt_oh;
                        end else begin
                            r_state <= S_RDATA;
                        end
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_state <= S_DONE;
                        r_ack   <= w_gnt_oh;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RDATA: begin
                    // Slave presents read data in the slot after acceptance.
                    r_state <= S_DONE;
                    r_ack   <= w_gnt_oh;
                    r_rdata <= m_rdata;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_nxt;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_sel     = (r_state == S_ISSUE) || (r_state == S_RDATA);
    assign m_wr      = r_wr;
    assign m_addr    = r_addr;
    assign m_wdata   = r_wdata;
    assign ack       = r_ack;
    assign err       = r_err;
    assign rsp_rdata = r_rdata;
    assign busy      = r_busy;
    assign gnt_id    = r_gnt;
endmodule
